// File: rtl/led_fader.sv
// led_fader: eight-channel LED dimmer. Each channel ramps its brightness
// level toward the synchronized garland pattern (or snaps to it when fading
// is disabled), and a free-running 8-bit PWM counter turns the level into
// a registered on/off drive.
`timescale 1ns/1ps

module led_fader #(
    parameter int STEP_DIV = 4096,  // CLK cycles per brightness step tick (>= 2)
    parameter int STEP     = 8      // level change per tick (1..255)
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PAT,
    input  logic       FADE_EN,
    output logic [7:0] LED,
    output logic       BUSY
);

    localparam int              PW        = $clog2(STEP_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [8:0]      STEP_9    = 9'(STEP);
    localparam logic [7:0]      STEP_8    = 8'(STEP);
    localparam logic [7:0]      LVL_MAX   = 8'hFF;
    localparam logic [7:0]      LVL_MIN   = 8'h00;

    logic [7:0]        pat_meta;
    logic [7:0]        pat_s;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [7:0]        pwm;
    logic [7:0][7:0]   level;
    logic [7:0][7:0]   level_nxt;
    logic [7:0][7:0]   target;
    logic [7:0]        led_nxt;
    logic              busy_nxt;

    // Brighten by one step, saturating at full scale via the 9-bit carry.
    function automatic logic [7:0] step_up(input logic [7:0] lv);
        logic [8:0] sum;
        sum = {1'b0, lv} + STEP_9;
        return sum[8] ? LVL_MAX : sum[7:0];
    endfunction

    // Dim by one step, clamping at zero instead of wrapping.
    function automatic logic [7:0] step_down(input logic [7:0] lv);
        return (lv >= STEP_8) ? (lv - STEP_8) : LVL_MIN;
    endfunction

    // Two-flop synchronizer: PAT comes from another clock domain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pat_meta <= '0;
            pat_s    <= '0;
        end else begin
            // NOTE: non-blocking so pat_s takes the old pat_meta, giving two real flop stages.
            pat_meta <= PAT;
            pat_s    <= pat_meta;
        end
    end

    // Step prescaler: counts 0..STEP_DIV-1 and wraps; runs regardless of FADE_EN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_ONE;
        end
    end

    assign tick = (presc == PRESC_MAX);

    // Free-running PWM phase counter, wraps 255 -> 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 8'd1;
        end
    end

    // Per-channel target extreme and next level (snap, ramp on tick, or hold).
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        level_nxt = level;
        target    = '0;
        for (int i = 0; i < 8; i++) begin
            target[i] = pat_s[i] ? LVL_MAX : LVL_MIN;
            if (!FADE_EN) begin
                level_nxt[i] = target[i];
            end else if (tick) begin
                level_nxt[i] = pat_s[i] ? step_up(level[i]) : step_down(level[i]);
            end
        end
    end

    // Level registers; a reset abandons any ramp and restarts every channel dark.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: only eight bytes of state, so the whole level array is reset rather than left unknown.
            level <= '0;
        end else begin
            level <= level_nxt;
        end
    end

    // PWM compare and busy detection, computed from the current levels.
    always_comb begin
        led_nxt  = '0;
        busy_nxt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            led_nxt[i] = (level[i] == LVL_MAX) | (pwm < level[i]);
            if (level[i] != target[i]) begin
                busy_nxt = 1'b1;
            end
        end
    end

    // Registered outputs so the LED pins are glitch-free.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED  <= '0;
            BUSY <= 1'b0;
        end else begin
            LED  <= led_nxt;
            BUSY <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed bench for led_fader. A fast instance (STEP_DIV=4,
// STEP=64) exercises ramps, reversal, instant mode and reset; a slow
// instance (STEP_DIV=1024, STEP=100) holds levels long enough to measure
// PWM duty and shows the 200 -> 255 saturation.
`timescale 1ns/1ps

module tb_led_fader;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] PAT;
    logic       FADE_EN;
    logic [7:0] LED;
    logic       BUSY;

    logic       s_rst_n;
    logic [7:0] s_pat;
    logic       s_fade_en;
    logic [7:0] s_led;
    logic       s_busy;

    int checks   = 0;
    int failures = 0;
    int duty_cnt = 0;

    always #5 CLK = ~CLK;

    led_fader #(.STEP_DIV(4), .STEP(64)) u_dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .PAT     (PAT),
        .FADE_EN (FADE_EN),
        .LED     (LED),
        .BUSY    (BUSY)
    );

    led_fader #(.STEP_DIV(1024), .STEP(100)) u_slow (
        .CLK     (CLK),
        .RST_N   (s_rst_n),
        .PAT     (s_pat),
        .FADE_EN (s_fade_en),
        .LED     (s_led),
        .BUSY    (s_busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; all sampling and driving happens on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST_N     = 1'b0;
        PAT       = 8'h00;
        FADE_EN   = 1'b1;
        s_rst_n   = 1'b0;
        s_pat     = 8'h00;
        s_fade_en = 1'b1;

        // Reset state
        cycles(2);
        check("rst_led", 16'(LED), 16'h00);
        check("rst_busy", 16'(BUSY), 16'h0);
        check("rst_level0", 16'(u_dut.level[0]), 16'h00);
        RST_N   = 1'b1;
        s_rst_n = 1'b1;

        // Idle pattern: dark and not busy for 1000 cycles
        for (int c = 0; c < 1000; c++) begin
            cycles(1);
            check("idle_led", 16'(LED), 16'h00);
            check("idle_busy", 16'(BUSY), 16'h0);
        end

        // Ramp up channel 0: 64,128,192,255 (prescaler is at 0 here)
        PAT = 8'h01;
        cycles(2);
        check("up_pre_tick", 16'(u_dut.level[0]), 16'd0);
        cycles(2);
        check("up_t1", 16'(u_dut.level[0]), 16'd64);
        check("up_busy", 16'(BUSY), 16'h1);
        cycles(1);
        check("up_hold", 16'(u_dut.level[0]), 16'd64);
        cycles(3);
        check("up_t2", 16'(u_dut.level[0]), 16'd128);
        cycles(4);
        check("up_t3", 16'(u_dut.level[0]), 16'd192);
        cycles(4);
        check("up_t4_sat", 16'(u_dut.level[0]), 16'd255);
        check("up_busy_last", 16'(BUSY), 16'h1);
        check("up_lvl1_dark", 16'(u_dut.level[1]), 16'd0);
        cycles(1);
        check("up_busy_done", 16'(BUSY), 16'h0);
        check("up_led_full", 16'(LED), 16'h01);
        for (int c = 0; c < 255; c++) begin
            cycles(1);
            check("full_led_const", 16'(LED), 16'h01);
        end

        // Ramp down: 191,127,63,0 with no wrap
        PAT = 8'h00;
        cycles(4);
        check("dn_t1", 16'(u_dut.level[0]), 16'd191);
        check("dn_busy", 16'(BUSY), 16'h1);
        cycles(4);
        check("dn_t2", 16'(u_dut.level[0]), 16'd127);
        cycles(4);
        check("dn_t3", 16'(u_dut.level[0]), 16'd63);
        cycles(4);
        check("dn_t4_zero", 16'(u_dut.level[0]), 16'd0);
        cycles(1);
        check("dn_busy_done", 16'(BUSY), 16'h0);
        for (int c = 0; c < 255; c++) begin
            cycles(1);
            check("dark_led_const", 16'(LED), 16'h00);
        end
        check("dn_no_wrap", 16'(u_dut.level[0]), 16'd0);

        // Reversal mid-ramp: up to 128, then flip to off -> 64
        PAT = 8'h01;
        cycles(8);
        check("rev_at_128", 16'(u_dut.level[0]), 16'd128);
        PAT = 8'h00;
        cycles(4);
        check("rev_to_64", 16'(u_dut.level[0]), 16'd64);
        cycles(4);
        check("rev_to_0", 16'(u_dut.level[0]), 16'd0);

        // Instant tracking with fading disabled
        FADE_EN = 1'b0;
        PAT     = 8'hFF;
        cycles(3);
        check("inst_busy_on", 16'(BUSY), 16'h1);
        cycles(1);
        check("inst_led_ff", 16'(LED), 16'hFF);
        check("inst_busy_off", 16'(BUSY), 16'h0);
        PAT = 8'h00;
        cycles(4);
        check("inst_led_00", 16'(LED), 16'h00);
        check("inst_busy_00", 16'(BUSY), 16'h0);

        // All channels ramp together, then an asynchronous reset mid-ramp
        FADE_EN = 1'b1;
        PAT     = 8'hFF;
        cycles(8);
        for (int i = 0; i < 8; i++) begin
            check("all_ch_128", 16'(u_dut.level[i]), 16'd128);
        end
        check("all_busy", 16'(BUSY), 16'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_led", 16'(LED), 16'h00);
        check("arst_busy", 16'(BUSY), 16'h0);
        check("arst_level", 16'(u_dut.level[3]), 16'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cycles(3);
        check("rel_no_tick_yet", 16'(u_dut.level[0]), 16'd0);
        cycles(1);
        check("rel_restart_ch0", 16'(u_dut.level[0]), 16'd64);
        check("rel_restart_ch7", 16'(u_dut.level[7]), 16'd64);

        // Slow instance: first tick timing, duty at level 100, saturation 200 -> 255
        s_rst_n = 1'b0;
        cycles(1);
        s_rst_n = 1'b1;
        s_pat   = 8'h01;
        cycles(1023);
        check("slow_pre_tick", 16'(u_slow.level[0]), 16'd0);
        cycles(1);
        check("slow_t1", 16'(u_slow.level[0]), 16'd100);
        cycles(6);
        for (int c = 0; c < 256; c++) begin
            cycles(1);
            if (s_led[0]) duty_cnt++;
        end
        check("slow_duty_100", 16'(duty_cnt), 16'd100);
        check("slow_busy", 16'(s_busy), 16'h1);
        cycles(762);
        check("slow_t2", 16'(u_slow.level[0]), 16'd200);
        cycles(1024);
        check("slow_t3_sat", 16'(u_slow.level[0]), 16'd255);
        cycles(2);
        check("slow_led_full", 16'(s_led), 16'h01);
        check("slow_busy_done", 16'(s_busy), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
